sipo_deser_nreg: RTL
====================

// Module: sipo_deser_nreg
// PURPOSE
//  Serial-to-parallel receiver: collects an N-bit word from a bit-serial stream (1 bit per strobe),
//  then presents it on a parallel output with a valid/ready handshake.
//  Companion to the team's parallel-load/serial-shift register (the transmit end).
//  Sits between a serial link and word-wide consumer logic.
//  Double-buffered: the next frame is shifted in while the previous word waits for the consumer.
// PARAMETERS
//  N          4   word width in bits (N >= 2)
//  MSB_FIRST  1   1: first received bit lands in dout[N-1]; 0: first bit lands in dout[0]
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   asynchronous, active-low reset
//  sin        in   1   serial data bit
//  sin_valid  in   1   sin is sampled on this edge when high
//  sof        in   1   start of frame; qualified by sin_valid, marks the first bit of a word
//  dout_ready in   1   consumer accepts dout when dout_valid & dout_ready
//  dout       out  N   received word (holding register)
//  dout_valid out  1   dout holds an unconsumed word
//  busy       out  1   frame in progress (state SHIFT)
//  bit_cnt    out  $clog2(N+1)  bits collected in current frame, 0..N-1
//  overrun    out  1   sticky: completed word dropped because holding register was full
//  frame_err  out  1   sticky: sof arrived mid-frame, partial word discarded
//  clr_err    in   1   synchronous clear of overrun and frame_err
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; shift reg, bit_cnt, dout=0; dout_valid, busy, overrun, frame_err=0.
//  FSM, states IDLE and SHIFT:
//   IDLE: sin_valid&sof -> bit 0 captured, bit_cnt=1, go to SHIFT.
//         sin_valid without sof is ignored.
//   SHIFT: each sin_valid shifts sin in, bit_cnt++.
//          Nth bit (bit_cnt==N-1 & sin_valid) -> word complete, bit_cnt=0, go to IDLE.
//          sin_valid&sof in SHIFT -> frame_err=1, partial discarded, bit captured as bit 0,
//          bit_cnt=1, stay in SHIFT.
//          No timeout: stays in SHIFT indefinitely while sin_valid=0.
//  Bit placement: MSB_FIRST=1 shifts left (sin enters LSB, first bit ends in dout[N-1]).
//                 MSB_FIRST=0 shifts right.
//  Latency: dout/dout_valid update on the same edge that samples the Nth bit.
//           Visible the cycle after the last strobe.
//  Handshake: dout stable while dout_valid & !dout_ready.
//             dout_valid falls on the accepting edge unless a new word completes on that edge.
//  Simultaneous completion + accept: new word loads, dout_valid stays 1, no overrun.
//  Completion while dout_valid & !dout_ready: new word dropped, dout unchanged, overrun=1.
//  N=1-bit frames impossible: N >= 2 is checked by an elaboration-time assertion.
//  clr_err clears the sticky flags.
//  clr_err in the same cycle as a new error event: the event wins (flag stays 1).
//  Reset mid-frame: partial word lost; holding register and dout_valid cleared.
//  bit_cnt width $clog2(N+1). Counter never exceeds N-1; no wrap beyond frame.
// STRUCTURE
//  Package sipo_pkg: typedef enum logic {IDLE, SHIFT} sipo_state_t.
//  Sub-module sipo_shift_core #(N, MSB_FIRST):
//   - shift register + bit counter
//   - inputs shift_en, restart
//   - outputs word, last_bit
//  Top level holds the FSM, holding register, handshake and sticky flags.
// TESTING  (N=4, MSB_FIRST=1 unless stated)
//  1. Reset: rst low mid-frame -> all outputs 0 immediately; next sof starts a clean frame.
//  2. Frame 1,0,1,1 with sof on first bit, dout_ready=1 -> dout=4'b1011, dout_valid 1 cycle after 4th strobe.
//  3. MSB_FIRST=0, same bits -> dout=4'b1101.
//  4. Two back-to-back frames 4'hA, 4'h5, dout_ready=0 -> dout stays 4'hA, overrun=1;
//     clr_err -> overrun=0.
//  5. Second frame completes on the same edge as dout_ready accept of the first -> dout=new word,
//     dout_valid stays 1, overrun=0.
//  6. sof after 2 bits -> frame_err=1, bit_cnt=1; 3 more strobes produce word from the new bits only;
//     gaps in sin_valid do not change the result.

Source files
------------

// File: rtl/sipo_deser_nreg_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared types for the serial-to-parallel receiver (sipo_deser_nreg).
//   sipo_state_t : receiver FSM state. IDLE waits for a start-of-frame bit.
//                  SHIFT collects the remaining bits of a word.
// ---------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

endpackage

// File: rtl/sipo_deser_nreg_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus bit counter for the serial receiver.
// The top-level FSM decides when a bit is taken. This block only moves data.
// Ports:
//   clk, rst  : clock and asynchronous active-low reset
//   sin       : serial data bit
//   shift_en  : take sin on this edge
//   restart   : the bit being taken is bit 0 of a fresh frame.
//               Any partial word is discarded.
//   word      : the assembled word including the bit currently on sin.
//               This is the value the holding register loads on completion.
//   last_bit  : the counter says the next accepted bit is the Nth one
//   cnt       : number of bits collected in the current frame (0..N-1)
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  input  logic                     shift_en,
  input  logic                     restart,
  output logic [N-1:0]             word,
  output logic                     last_bit,
  output logic [$clog2(N+1)-1:0]   cnt
);

  localparam int CW = $clog2(N+1);

  logic [N-1:0]  sreg_q, sreg_d;
  logic [N-1:0]  base;
  logic [N-1:0]  shifted;
  logic [CW-1:0] cnt_q, cnt_d;

  // A restart shifts into an all-zero register.
  // The first bit of the new frame therefore always lands in a clean word.
  always_comb begin
    base = restart ? '0 : sreg_q;
    if (MSB_FIRST) begin
      shifted = {base[N-2:0], sin};
    end else begin
      shifted = {sin, base[N-1:1]};
    end
  end

  assign word     = shifted;
  assign last_bit = (cnt_q == CW'(N-1));
  assign cnt      = cnt_q;

  // The counter never passes N-1.
  // On the Nth bit, the word leaves through 'word' and the register is cleared for the next frame.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (shift_en) begin
      if (restart) begin
        sreg_d = shifted;
        cnt_d  = CW'(1);
      end else if (last_bit) begin
        sreg_d = '0;
        cnt_d  = '0;
      end else begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deser_nreg.sv
// ---------------------------------------------------------------------------
// sipo_deser_nreg
// Double-buffered serial-to-parallel receiver.
// It collects an N-bit word, one bit per sin_valid strobe.
// It presents the word on dout with a valid/ready handshake.
// The next frame shifts in while the previous word waits for the consumer.
// Ports:
//   clk, rst    : clock and asynchronous active-low reset
//   sin         : serial data bit
//   sin_valid   : sin is sampled on this edge
//   sof         : marks the first bit of a word (qualified by sin_valid)
//   dout_ready  : consumer accepts dout when dout_valid & dout_ready
//   dout        : holding register with the last received word
//   dout_valid  : dout holds an unconsumed word
//   busy        : a frame is in progress
//   bit_cnt     : bits collected in the current frame
//   overrun     : sticky, a completed word was dropped because dout was full
//   frame_err   : sticky, sof arrived mid-frame
//   clr_err     : synchronous clear of the sticky flags
// ---------------------------------------------------------------------------
module sipo_deser_nreg
  import sipo_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sof,
  input  logic                     dout_ready,
  input  logic                     clr_err,
  output logic [N-1:0]             dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic [$clog2(N+1)-1:0]   bit_cnt,
  output logic                     overrun,
  output logic                     frame_err
);

  if (N < 2) begin : gBadWidth
    $error("sipo_deser_nreg: N must be at least 2");
  end

  sipo_state_t   state_q, state_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          doutValid_q, doutValid_d;
  logic          overrun_q, overrun_d;
  logic          frameErr_q, frameErr_d;

  logic          inShift;
  logic          shiftEn;
  logic          complete;
  logic          frameErrEvt;
  logic          overrunEvt;
  logic [N-1:0]  coreWord;
  logic          coreLast;

  // A sof outside a frame starts one.
  // A sof inside a frame restarts it.
  // Plain strobes only count while a frame is open.
  assign inShift     = (state_q == SHIFT);
  assign shiftEn     = sin_valid & (inShift | sof);
  assign complete    = sin_valid & inShift & ~sof & coreLast;
  assign frameErrEvt = sin_valid & sof & inShift;
  assign overrunEvt  = complete & doutValid_q & ~dout_ready;

  sipo_shift_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) uCore (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .shift_en (shiftEn),
    .restart  (sof),
    .word     (coreWord),
    .last_bit (coreLast),
    .cnt      (bit_cnt)
  );

  // The FSM only tracks whether a frame is open.
  // A restart inside SHIFT keeps it in SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sin_valid && sof) state_d = SHIFT;
      SHIFT:   if (complete)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The holding register loads a finished word only if it is empty or being emptied on this edge.
  // Otherwise the new word is dropped and dout keeps the unconsumed one.
  always_comb begin
    dout_d      = dout_q;
    doutValid_d = doutValid_q;
    if (complete && (!doutValid_q || dout_ready)) begin
      dout_d      = coreWord;
      doutValid_d = 1'b1;
    end else if (doutValid_q && dout_ready) begin
      doutValid_d = 1'b0;
    end
  end

  // In the sticky flags, a new error event beats a simultaneous clear.
  always_comb begin
    overrun_d  = overrun_q;
    frameErr_d = frameErr_q;
    if (clr_err) begin
      overrun_d  = 1'b0;
      frameErr_d = 1'b0;
    end
    if (overrunEvt)  overrun_d  = 1'b1;
    if (frameErrEvt) frameErr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
      overrun_q   <= overrun_d;
      frameErr_q  <= frameErr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign busy       = inShift;
  assign overrun    = overrun_q;
  assign frame_err  = frameErr_q;

endmodule
